// File: rtl/word_stability_filter.sv
// Filters a word arriving from a handshake-free synchronizer. A new value is committed
// only after it has been sampled unchanged for STABLE_CYCLES consecutive cycles.
module word_stability_filter #(
  parameter int DATA_WIDTH     = 32,
  parameter int STABLE_CYCLES  = 4,
  parameter int GLITCH_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    glitch_clear,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    update,
  output logic                    settling,
  output logic                    stale,
  output logic [GLITCH_WIDTH-1:0] glitch_count
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("word_stability_filter: STABLE_CYCLES must be >= 1");
  end

  localparam int              RUN_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES - 1);
  localparam bit              TMO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int              TMO_W   = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_EN ? TMO_W'(TIMEOUT_CYCLES) : '0;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOCKED,
    ST_SETTLING
  } state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   prev;
  logic [RUN_W-1:0]        run, run_next;
  logic [TMO_W-1:0]        tmo, tmo_next;
  logic                    stale_next;
  logic [GLITCH_WIDTH-1:0] glitch_next;
  logic                    eq, differs, commit, glitch_hit, settle_stay;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    eq      = (data_in == prev);
    differs = (data_in != data_out);
    commit  = eq && (run == RUN_MAX) && (!data_valid || differs);

    run_next = '0;
    if (eq) run_next = (run == RUN_MAX) ? run : run + 1'b1;

    state_next = state;
    unique case (state)
      ST_EMPTY:    if (commit) state_next = ST_LOCKED;
      ST_LOCKED:   if (differs) state_next = ST_SETTLING;
      ST_SETTLING: if (commit || !differs) state_next = ST_LOCKED;
      default:     state_next = ST_EMPTY;
    endcase
  end

  // A break only counts as a glitch if the abandoned value had already repeated once;
  // single-cycle intermediate values are expected skew, not instability.
  always_comb begin
    glitch_hit  = (state == ST_SETTLING) && !eq && (run != '0);
    glitch_next = glitch_count;
    if (glitch_clear)
      glitch_next = '0;
    else if (glitch_hit && (glitch_count != '1))
      glitch_next = glitch_count + 1'b1;
  end

  // The timeout only runs across cycles that start and end in SETTLING; any exit clears it.
  always_comb begin
    settle_stay = (state == ST_SETTLING) && (state_next == ST_SETTLING);
    tmo_next    = '0;
    stale_next  = 1'b0;
    if (settle_stay && TMO_EN) begin
      tmo_next   = (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
      stale_next = stale || (tmo_next == TMO_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev         <= '0;
      run          <= '0;
      tmo          <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      update       <= 1'b0;
      stale        <= 1'b0;
      glitch_count <= '0;
    end else begin
      prev         <= data_in;
      run          <= run_next;
      tmo          <= tmo_next;
      stale        <= stale_next;
      glitch_count <= glitch_next;
      update       <= commit;
      if (commit) begin
        data_out   <= data_in;
        data_valid <= 1'b1;
      end
    end
  end

  assign settling = (state == ST_SETTLING);

endmodule

// File: tb/tb_word_stability_filter.sv
// Randomized and directed bench for word_stability_filter: two instances (wide and narrow
// glitch counter, timeout on/off) share stimulus and are scored against a sample-history model.
module tb_word_stability_filter;

  localparam int DW   = 32;
  localparam int S    = 4;
  localparam int GW_M = 8;
  localparam int GW_S = 2;
  localparam int T_M  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = 32'hDEAD_BEEF;
  logic          glitch_clear = 1'b0;

  logic [DW-1:0]   data_out_m, data_out_s;
  logic            data_valid_m, data_valid_s, update_m, update_s;
  logic            settling_m, settling_s, stale_m, stale_s;
  logic [GW_M-1:0] glitch_m;
  logic [GW_S-1:0] glitch_s;

  always #5 clk = ~clk;

  word_stability_filter #(.DATA_WIDTH(DW), .STABLE_CYCLES(S), .GLITCH_WIDTH(GW_M),
                          .TIMEOUT_CYCLES(T_M)) u_main (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .glitch_clear(glitch_clear),
    .data_out(data_out_m), .data_valid(data_valid_m), .update(update_m),
    .settling(settling_m), .stale(stale_m), .glitch_count(glitch_m));

  word_stability_filter #(.DATA_WIDTH(DW), .STABLE_CYCLES(S), .GLITCH_WIDTH(GW_S),
                          .TIMEOUT_CYCLES(0)) u_small (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .glitch_clear(glitch_clear),
    .data_out(data_out_s), .data_valid(data_valid_s), .update(update_s),
    .settling(settling_s), .stale(stale_s), .glitch_count(glitch_s));

  int n_checks = 0;
  int n_pass   = 0;
  int n_updates = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] dout;
    bit            valid, upd, settling, stale;
    int            gm, gs;
  } exp_t;

  exp_t          status_q[$];
  logic [DW-1:0] commit_q[$];
  logic [DW-1:0] hist[$];   // most recent samples of data_in, oldest first
  logic [DW-1:0] m_dout;
  bit            m_valid, m_upd, m_settling, m_stale;
  int            m_settle_len, m_gm, m_gs;

  function automatic exp_t snapshot();
    exp_t e;
    e.dout = m_dout; e.valid = m_valid; e.upd = m_upd;
    e.settling = m_settling; e.stale = m_stale; e.gm = m_gm; e.gs = m_gs;
    return e;
  endfunction

  task automatic model_reset();
    status_q.delete();
    commit_q.delete();
    hist.delete();
    hist.push_back('0);      // the reset value of the previous sample
    m_dout = '0; m_valid = 0; m_upd = 0; m_settling = 0; m_stale = 0;
    m_settle_len = 0; m_gm = 0; m_gs = 0;
    status_q.push_back(snapshot());
  endtask

  task automatic model_step();
    logic [DW-1:0] din;
    bit gclr, repeated, all_eq, commit, gev, now_settling;
    din = data_in;
    gclr = glitch_clear;
    repeated = (hist.size() >= 2) && (hist[hist.size()-1] == hist[hist.size()-2]);
    gev = m_settling && (din != hist[hist.size()-1]) && repeated;
    hist.push_back(din);
    if (hist.size() > S + 1) void'(hist.pop_front());
    all_eq = (hist.size() == S + 1);
    foreach (hist[i]) if (hist[i] != din) all_eq = 0;
    commit = all_eq && (!m_valid || din != m_dout);
    now_settling = m_valid && (din != m_dout) && !commit;

    if (gclr) begin m_gm = 0; m_gs = 0; end
    else if (gev) begin
      if (m_gm < (1 << GW_M) - 1) m_gm++;
      if (m_gs < (1 << GW_S) - 1) m_gs++;
    end
    m_settle_len = (m_settling && now_settling) ? m_settle_len + 1 : 0;
    m_stale = (m_settle_len >= T_M);
    m_settling = now_settling;
    m_upd = commit;
    if (commit) begin
      m_dout = din;
      m_valid = 1;
      commit_q.push_back(din);
    end
    status_q.push_back(snapshot());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic [DW-1:0] want;
    forever begin
      @(negedge clk);
      if (status_q.size() > 0) begin
        e = status_q.pop_front();
        check("data_out_m",   data_out_m,   e.dout);
        check("data_out_s",   data_out_s,   e.dout);
        check("data_valid_m", data_valid_m, 32'(e.valid));
        check("update_m",     update_m,     32'(e.upd));
        check("update_s",     update_s,     32'(e.upd));
        check("settling_m",   settling_m,   32'(e.settling));
        check("settling_s",   settling_s,   32'(e.settling));
        check("stale_m",      stale_m,      32'(e.stale));
        check("stale_s",      stale_s,      32'd0);
        check("glitch_m",     32'(glitch_m), 32'(e.gm));
        check("glitch_s",     32'(glitch_s), 32'(e.gs));
      end
      if (update_m) begin
        n_updates++;
        if (commit_q.size() == 0) check("update_unexpected", data_out_m, '0 - 1);
        else begin
          want = commit_q.pop_front();
          check("update_word", data_out_m, want);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [DW-1:0] v, input int n);
    data_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!update_m && n < 20);
    check(name, n, S + 1);
  endtask

  initial begin
    int u0, g0, gs0;
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int u0, g0;
    // Reset held with a live word on the input, then a full run to commit.
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out_m, 32'h0);
    check("reset_valid", data_valid_m, 32'h0);
    rst_n = 1'b1;
    measure_latency("reset_release_latency");
    check("first_commit", data_out_m, 32'hDEAD_BEEF);

    // Skew transient: one intermediate value between two stable words.
    hold(32'h0000_000A, 8);
    u0 = n_updates; g0 = glitch_m;
    hold(32'h0000_000B, 1);
    hold(32'h0000_000C, 8);
    check("skew_one_update", n_updates - u0, 1);
    check("skew_final", data_out_m, 32'h0000_000C);
    check("skew_no_glitch", glitch_m, g0);

    // Brief excursion that returns to the committed word.
    hold(32'h0000_0055, 8);
    u0 = n_updates;
    hold(32'h0000_0066, 2);
    hold(32'h0000_0055, 6);
    check("return_no_update", n_updates - u0, 0);
    check("return_locked", settling_m, 0);

    // Broken runs long enough to go stale, then a steady value commits.
    hold(32'h0, 8);
    g0 = glitch_m;
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 32'h1 : 32'h2, 3);
    check("broken_settling", settling_m, 1);
    check("broken_stale", stale_m, 1);
    check("broken_glitches", glitch_m - g0, 9);
    check("small_saturated", glitch_s, 3);
    hold(32'h2, 8);
    check("broken_commit", data_out_m, 32'h2);
    check("broken_stale_cleared", stale_m, 0);

    // Clear coinciding with a counted break.
    hold(32'h7, 8);
    hold(32'h1, 3);
    data_in = 32'h2;
    glitch_clear = 1'b1;
    @(negedge clk);
    glitch_clear = 1'b0;
    check("clear_priority_m", glitch_m, 0);
    check("clear_priority_s", glitch_s, 0);
    hold(32'h2, 8);

    // Randomized words and hold lengths with occasional clears.
    for (int i = 0; i < 300; i++) begin
      glitch_clear = ($urandom_range(0, 15) == 0);
      data_in = 32'hA5A5_0000 | 32'($urandom_range(0, 3));
      @(negedge clk);
      glitch_clear = 1'b0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // Asynchronous reset between clock edges while settling.
    hold(32'h11, 8);
    hold(32'h22, 2);
    check("pre_reset_settling", settling_m, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_data_out", data_out_m, 32'h0);
    check("async_valid", data_valid_m, 0);
    check("async_settling", settling_m, 0);
    check("async_update", update_m, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure_latency("post_reset_latency");
    check("post_reset_commit", data_out_m, 32'h22);

    repeat (4) @(negedge clk);
    check("commit_queue_drained", commit_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
